// File: rtl/ex_wb_stage_pkg.sv
// Shared core constants for the writeback slice: null register IDs, NOP uCmd
// and register-ID widths.
package ex_wb_stage_pkg;
  localparam int unsigned GPR_ID_W = 6;
  localparam int unsigned CR_ID_W  = 5;
  localparam int unsigned UCMD_W   = 6;

  localparam logic [GPR_ID_W-1:0] JX2_GR_ZZR   = 6'h3F;
  localparam logic [CR_ID_W-1:0]  JX2_CR_ZZR   = 5'h1F;
  localparam logic [UCMD_W-1:0]   JX2_UCMD_NOP = 6'h00;
endpackage

// File: rtl/ex_hold_watchdog.sv
// Stuck-hold watchdog: saturating count of consecutive hold cycles with a
// sticky flag that sets when the count reaches HOLD_LIMIT.
module ex_hold_watchdog #(
  parameter logic [15:0] HOLD_LIMIT = 16'd4096
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  output logic timeout
);
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (hold) begin
      if (cnt != '1) cnt_nxt = cnt + 16'd1;
    end else begin
      cnt_nxt = '0;
    end
  end

  // Compare the incremented value so the flag rises on the same edge the
  // count reaches the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (hold && (cnt_nxt == HOLD_LIMIT)) timeout <= 1'b1;
    end
  end
endmodule

// File: rtl/ex_wb_stage.sv
// Lane-1 writeback stage: registers EX3 GPR/CR results, issues one write per
// retired op, exposes a hold-stable bypass copy, counts retires.
module ex_wb_stage
  import ex_wb_stage_pkg::*;
#(
  parameter logic [GPR_ID_W-1:0] GPR_ZZR    = JX2_GR_ZZR,
  parameter logic [CR_ID_W-1:0]  CR_ZZR     = JX2_CR_ZZR,
  parameter logic [UCMD_W-1:0]   UCMD_NOP   = JX2_UCMD_NOP,
  parameter logic [15:0]         HOLD_LIMIT = 16'd4096
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                exHold,
  input  logic                opBraFlush,
  input  logic [UCMD_W-1:0]   opUCmd,
  input  logic [GPR_ID_W-1:0] regIdRn2,
  input  logic [63:0]         regValRn2,
  input  logic [CR_ID_W-1:0]  regIdCn2,
  input  logic [63:0]         regValCn2,
  output logic                gprWrEn,
  output logic [GPR_ID_W-1:0] gprWrId,
  output logic [63:0]         gprWrVal,
  output logic                crWrEn,
  output logic [CR_ID_W-1:0]  crWrId,
  output logic [63:0]         crWrVal,
  output logic [GPR_ID_W-1:0] regIdRnW,
  output logic [63:0]         regValRnW,
  output logic [31:0]         retireCnt,
  output logic                holdTimeout
);
  logic                valid;
  logic [GPR_ID_W-1:0] gpr_id;
  logic [63:0]         gpr_val;
  logic [CR_ID_W-1:0]  cr_id;
  logic [63:0]         cr_val;

  // valid drops during hold so a held op is written only on its first WB cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid     <= 1'b0;
      gpr_id    <= GPR_ZZR;
      gpr_val   <= '0;
      cr_id     <= CR_ZZR;
      cr_val    <= '0;
      retireCnt <= '0;
    end else if (!exHold) begin
      valid   <= 1'b1;
      gpr_id  <= opBraFlush ? GPR_ZZR : regIdRn2;
      gpr_val <= regValRn2;
      cr_id   <= opBraFlush ? CR_ZZR : regIdCn2;
      cr_val  <= regValCn2;
      if (!opBraFlush && (opUCmd != UCMD_NOP)) retireCnt <= retireCnt + 32'd1;
    end else begin
      valid <= 1'b0;
    end
  end

  assign gprWrEn   = valid && (gpr_id != GPR_ZZR);
  assign crWrEn    = valid && (cr_id != CR_ZZR);
  assign gprWrId   = gpr_id;
  assign gprWrVal  = gpr_val;
  assign crWrId    = cr_id;
  assign crWrVal   = cr_val;
  assign regIdRnW  = gpr_id;
  assign regValRnW = gpr_val;

  ex_hold_watchdog #(
    .HOLD_LIMIT(HOLD_LIMIT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .hold   (exHold),
    .timeout(holdTimeout)
  );
endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: vector table through an expected-result queue, plus
// hand sequences for counter wrap, watchdog and reset-during-hold.
module tb_ex_wb_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        exHold;
  logic        opBraFlush;
  logic [5:0]  opUCmd;
  logic [5:0]  regIdRn2;
  logic [63:0] regValRn2;
  logic [4:0]  regIdCn2;
  logic [63:0] regValCn2;
  logic        gprWrEn;
  logic [5:0]  gprWrId;
  logic [63:0] gprWrVal;
  logic        crWrEn;
  logic [4:0]  crWrId;
  logic [63:0] crWrVal;
  logic [5:0]  regIdRnW;
  logic [63:0] regValRnW;
  logic [31:0] retireCnt;
  logic        holdTimeout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  ex_wb_stage #(
    .HOLD_LIMIT(16'd8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .exHold     (exHold),
    .opBraFlush (opBraFlush),
    .opUCmd     (opUCmd),
    .regIdRn2   (regIdRn2),
    .regValRn2  (regValRn2),
    .regIdCn2   (regIdCn2),
    .regValCn2  (regValCn2),
    .gprWrEn    (gprWrEn),
    .gprWrId    (gprWrId),
    .gprWrVal   (gprWrVal),
    .crWrEn     (crWrEn),
    .crWrId     (crWrId),
    .crWrVal    (crWrVal),
    .regIdRnW   (regIdRnW),
    .regValRnW  (regValRnW),
    .retireCnt  (retireCnt),
    .holdTimeout(holdTimeout)
  );

  typedef struct {
    logic        hold;
    logic        flush;
    logic [5:0]  ucmd;
    logic [5:0]  idr;
    logic [63:0] valr;
    logic [4:0]  idc;
    logic [63:0] valc;
  } in_t;

  typedef struct {
    logic        gen;
    logic [5:0]  gid;
    logic [63:0] gval;
    logic        cen;
    logic [4:0]  cid;
    logic [63:0] cval;
    logic [31:0] rc;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t tbl[11];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic hold, input logic flush, input logic [5:0] ucmd,
                              input logic [5:0] idr, input logic [63:0] valr,
                              input logic [4:0] idc, input logic [63:0] valc,
                              input logic gen, input logic [5:0] gid, input logic [63:0] gval,
                              input logic cen, input logic [4:0] cid, input logic [63:0] cval,
                              input logic [31:0] rc);
    vec_t v;
    v.i.hold = hold; v.i.flush = flush; v.i.ucmd = ucmd;
    v.i.idr = idr; v.i.valr = valr; v.i.idc = idc; v.i.valc = valc;
    v.e.gen = gen; v.e.gid = gid; v.e.gval = gval;
    v.e.cen = cen; v.e.cid = cid; v.e.cval = cval; v.e.rc = rc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic hold, input logic flush, input logic [5:0] ucmd,
                       input logic [5:0] idr, input logic [63:0] valr,
                       input logic [4:0] idc, input logic [63:0] valc);
    exHold = hold; opBraFlush = flush; opUCmd = ucmd;
    regIdRn2 = idr; regValRn2 = valr; regIdCn2 = idc; regValCn2 = valc;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Retire count accumulates across rows; GPR bypass expected equals gid/gval.
    tbl[0]  = mk(0, 0, 6'h00, 6'h3F, 64'h0,    5'h1F, 64'h0,    0, 6'h3F, 64'h0,    0, 5'h1F, 64'h0,    0);
    tbl[1]  = mk(0, 0, 6'h12, 6'h04, 64'h1234, 5'h1F, 64'h0,    1, 6'h04, 64'h1234, 0, 5'h1F, 64'h0,    1);
    tbl[2]  = mk(1, 0, 6'h12, 6'h09, 64'hDEAD, 5'h05, 64'hBEEF, 0, 6'h04, 64'h1234, 0, 5'h1F, 64'h0,    1);
    tbl[3]  = mk(1, 1, 6'h12, 6'h09, 64'hDEAD, 5'h05, 64'hBEEF, 0, 6'h04, 64'h1234, 0, 5'h1F, 64'h0,    1);
    tbl[4]  = mk(1, 0, 6'h13, 6'h0C, 64'h77,   5'h06, 64'h88,   0, 6'h04, 64'h1234, 0, 5'h1F, 64'h0,    1);
    tbl[5]  = mk(1, 0, 6'h12, 6'h09, 64'hDEAD, 5'h05, 64'hBEEF, 0, 6'h04, 64'h1234, 0, 5'h1F, 64'h0,    1);
    tbl[6]  = mk(1, 0, 6'h12, 6'h09, 64'hDEAD, 5'h05, 64'hBEEF, 0, 6'h04, 64'h1234, 0, 5'h1F, 64'h0,    1);
    tbl[7]  = mk(0, 1, 6'h12, 6'h07, 64'h55,   5'h02, 64'h66,   0, 6'h3F, 64'h55,   0, 5'h1F, 64'h66,   1);
    tbl[8]  = mk(0, 0, 6'h05, 6'h0A, 64'hAAAA, 5'h03, 64'hBBBB, 1, 6'h0A, 64'hAAAA, 1, 5'h03, 64'hBBBB, 2);
    tbl[9]  = mk(0, 0, 6'h00, 6'h0B, 64'h1,    5'h1F, 64'h2,    1, 6'h0B, 64'h1,    0, 5'h1F, 64'h2,    2);
    tbl[10] = mk(0, 0, 6'h01, 6'h3F, 64'h3,    5'h04, 64'h4,    0, 6'h3F, 64'h3,    1, 5'h04, 64'h4,    3);

    // Reset dominates a capture presented in the same cycle.
    reset = 1'b1;
    drive(0, 0, 6'h12, 6'h04, 64'h99, 5'h02, 64'h98);
    step();
    step();
    chk("rst_gprWrEn", 64'(gprWrEn), 64'h0);
    chk("rst_crWrEn", 64'(crWrEn), 64'h0);
    chk("rst_gprWrId", 64'(gprWrId), 64'h3F);
    chk("rst_crWrId", 64'(crWrId), 64'h1F);
    chk("rst_regIdRnW", 64'(regIdRnW), 64'h3F);
    chk("rst_gprWrVal", gprWrVal, 64'h0);
    chk("rst_retireCnt", 64'(retireCnt), 64'h0);
    chk("rst_holdTimeout", 64'(holdTimeout), 64'h0);

    for (int i = 0; i < 11; i++) begin
      exp_t e;
      @(negedge clock);
      reset = 1'b0;
      drive(tbl[i].i.hold, tbl[i].i.flush, tbl[i].i.ucmd, tbl[i].i.idr,
            tbl[i].i.valr, tbl[i].i.idc, tbl[i].i.valc);
      exp_q.push_back(tbl[i].e);
      step();
      e = exp_q.pop_front();
      chk($sformatf("v%0d_gprWrEn", i), 64'(gprWrEn), 64'(e.gen));
      chk($sformatf("v%0d_gprWrId", i), 64'(gprWrId), 64'(e.gid));
      chk($sformatf("v%0d_gprWrVal", i), gprWrVal, e.gval);
      chk($sformatf("v%0d_crWrEn", i), 64'(crWrEn), 64'(e.cen));
      chk($sformatf("v%0d_crWrId", i), 64'(crWrId), 64'(e.cid));
      chk($sformatf("v%0d_crWrVal", i), crWrVal, e.cval);
      chk($sformatf("v%0d_regIdRnW", i), 64'(regIdRnW), 64'(e.gid));
      chk($sformatf("v%0d_regValRnW", i), regValRnW, e.gval);
      chk($sformatf("v%0d_retireCnt", i), 64'(retireCnt), 64'(e.rc));
      chk($sformatf("v%0d_holdTimeout", i), 64'(holdTimeout), 64'h0);
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end

    // Retire counter wrap from all-ones, then a NOP that must not count.
    @(negedge clock);
    drive(0, 0, 6'h00, 6'h3F, 64'h0, 5'h1F, 64'h0);
    force dut.retireCnt = 32'hFFFF_FFFF;
    @(posedge clock);
    @(negedge clock);
    release dut.retireCnt;
    drive(0, 0, 6'h21, 6'h01, 64'h10, 5'h1F, 64'h0);
    step();
    chk("wrap_retireCnt", 64'(retireCnt), 64'h0);
    @(negedge clock);
    drive(0, 0, 6'h00, 6'h02, 64'h20, 5'h1F, 64'h0);
    step();
    chk("nop_retireCnt", 64'(retireCnt), 64'h0);
    chk("nop_gprWrEn", 64'(gprWrEn), 64'h1);
    @(negedge clock);
    drive(0, 0, 6'h22, 6'h03, 64'h30, 5'h1F, 64'h0);
    step();
    chk("post_wrap_retireCnt", 64'(retireCnt), 64'h1);

    // Watchdog at limit 8: clear before the 8th hold cycle, set on it, sticky after.
    @(negedge clock);
    exHold = 1'b1;
    for (int c = 0; c < 7; c++) step();
    chk("wd_7_holdTimeout", 64'(holdTimeout), 64'h0);
    step();
    chk("wd_8_holdTimeout", 64'(holdTimeout), 64'h1);
    @(negedge clock);
    exHold = 1'b0;
    for (int c = 0; c < 3; c++) step();
    chk("wd_sticky_holdTimeout", 64'(holdTimeout), 64'h1);

    // Reset mid-hold clears flag and counter; a full 8 hold cycles is needed again.
    @(negedge clock);
    exHold = 1'b1;
    for (int c = 0; c < 3; c++) step();
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("rsthold_holdTimeout", 64'(holdTimeout), 64'h0);
    chk("rsthold_retireCnt", 64'(retireCnt), 64'h0);
    chk("rsthold_regIdRnW", 64'(regIdRnW), 64'h3F);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 7; c++) step();
    chk("rsthold_7_holdTimeout", 64'(holdTimeout), 64'h0);
    step();
    chk("rsthold_8_holdTimeout", 64'(holdTimeout), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Writeback stage directly downstream of the lane-1 EX3 stage.
- Registers the EX3 GPR and CR destination pairs (regIdRn2/regValRn2, regIdCn2/regValCn2) and issues exactly one register-file write per retired op.
- Holds a stable bypass copy of the last result for the forwarding network.
- Maintains a retire counter and a stuck-hold watchdog.

Parameters:
- GPR_ZZR, 6'h3F, GPR null-destination ID; writes to it are suppressed.
- CR_ZZR, 5'h1F, CR null-destination ID; writes to it are suppressed.
- UCMD_NOP, 6'h00, uCmd value that does not count as retired.
- HOLD_LIMIT, 16'd4096, consecutive hold cycles before holdTimeout sets.

Ports:
- clock  in  1  core clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- exHold  in  1  pipeline hold (OR of stage holds; includes EX3 exHold[0]).
- opBraFlush  in  1  branch flush for the op currently in EX3.
- opUCmd  in  6  uCmd of the op in EX3 (low 6 bits).
- regIdRn2  in  6  GPR destination ID from EX3.
- regValRn2  in  64  GPR destination value from EX3.
- regIdCn2  in  5  CR destination ID from EX3.
- regValCn2  in  64  CR destination value from EX3.
- gprWrEn  out  1  GPR write strobe.
- gprWrId  out  6  GPR write ID.
- gprWrVal  out  64  GPR write value.
- crWrEn  out  1  CR write strobe.
- crWrId  out  5  CR write ID.
- crWrVal  out  64  CR write value.
- regIdRnW  out  6  bypass ID; stable across hold.
- regValRnW  out  64  bypass value.
- retireCnt  out  32  retired-op count; wraps.
- holdTimeout  out  1  sticky stuck-hold flag.

Behaviour:
- Reset (synchronous, dominates every other input in the same cycle):
  - gprWrEn=0, crWrEn=0.
  - gprWrId=regIdRnW=GPR_ZZR; crWrId=CR_ZZR.
  - All values 0, retireCnt=0, holdTimeout=0, internal valid=0, hold counter=0.
- Capture (posedge, exHold=0):
  - Latch the EX3 IDs and values into the stage register. Latency is 1 cycle from EX3 combinational outputs to the write ports.
  - valid<=1.
  - If opBraFlush=1, latched IDs are forced to GPR_ZZR/CR_ZZR, independent of the values EX3 supplies.
- Hold (posedge, exHold=1):
  - Stage register (IDs, values, bypass outputs) keeps its contents; valid<=0.
  - The op captured before the hold is therefore written exactly once, on its first cycle in WB, never repeated.
- Write strobes (registered outputs):
  - gprWrEn = valid & (gprWrId!=GPR_ZZR).
  - crWrEn = valid & (crWrId!=CR_ZZR).
  - Ids/values are always driven, even when the strobe is 0.
- Bypass: regIdRnW/regValRnW mirror the stage register and do not depend on valid, so forwarding stays correct during holds.
- Retire counter:
  - Increments by 1 on every capture with opBraFlush=0 and opUCmd!=UCMD_NOP.
  - Modulo 2^32; 32'hFFFFFFFF -> 0.
  - No increment while exHold=1.
- Hold watchdog:
  - 16-bit counter increments each exHold=1 cycle, saturating at 16'hFFFF; clears to 0 the cycle after exHold=0.
  - When the counter reaches HOLD_LIMIT (compare ==), holdTimeout<=1. It stays 1 until reset, even after hold drops.
- Simultaneous events:
  - opBraFlush during exHold is ignored; the flush is sampled only at capture.
  - Reset mid-hold clears both the watchdog and the sticky flag.
- Purely synchronous; no combinational path from inputs to outputs.

Decomposition:
- Shared package (CoreDefs): JX2_GR_ZZR, JX2_CR_ZZR, JX2_UCMD_NOP, register-ID widths. Parameter defaults are taken from these constants.
- One sub-module is natural: ex_hold_watchdog (saturating counter, limit compare, sticky flag). It is reused by other stages.
- Stage register and retire counter stay inline.

Test Plan:
- Reset, then idle with exHold=0 and IDs=ZZR -> gprWrEn=crWrEn=0, retireCnt=0, regIdRnW=6'h3F.
- Capture regIdRn2=6'h04, regValRn2=64'h1234, opUCmd=6'h12 -> next cycle: gprWrEn=1, gprWrId=4, gprWrVal=64'h1234, retireCnt=1.
- Same op, then exHold=1 for 5 cycles -> gprWrEn=1 for one cycle only; regIdRnW=4 and regValRnW=64'h1234 held all 5 cycles; retireCnt stays 1.
- Capture with opBraFlush=1, regIdRn2=6'h07, regIdCn2=5'h02 -> gprWrEn=crWrEn=0, regIdRnW=6'h3F, retireCnt unchanged.
- Preload retireCnt=32'hFFFFFFFF (force), capture non-NOP -> retireCnt=0. Capture UCMD_NOP -> no increment.
- HOLD_LIMIT=8, exHold=1 for 8 cycles -> holdTimeout=1 after the 8th; release hold -> flag stays 1; reset -> 0.
